// File: rtl/data_ram_pkg.sv
// Shared encodings for the data RAM: access sizes, FSM state type and the
// alignment rule used when a request is sampled.
package data_ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A request is rejected for the reserved size or natural misalignment.
  function automatic logic req_illegal(input logic [1:0] size,
                                       input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_ram_mem_lane_align.sv
// Byte-lane steering between the big-endian 4-byte window at addr and the
// right-justified CPU data: load extraction/extension, store lane placement.
module mem_lane_align
  import data_ram_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word,
  output logic [3:0]  st_be
);

  logic ext;

  // rd_word[31:24] is always the byte at addr, so the sign bit is fixed there.
  assign ext = sign & rd_word[31];

  always_comb begin
    ld_data = '0;
    st_word = '0;
    st_be   = 4'b0000;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{ext}}, rd_word[31:24]};
        st_word = {wr_data[7:0], 24'h000000};
        st_be   = 4'b1000;
      end
      SZ_HALF: begin
        ld_data = {{16{ext}}, rd_word[31:16]};
        st_word = {wr_data[15:0], 16'h0000};
        st_be   = 4'b1100;
      end
      SZ_WORD: begin
        ld_data = rd_word;
        st_word = wr_data;
        st_be   = 4'b1111;
      end
      default: begin
        ld_data = '0;
        st_word = '0;
        st_be   = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Byte-addressed big-endian data RAM; a legal access commits LATENCY edges after
// sampling, rejects commit-free in one edge; mfc is held until mov drops.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 512,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mov,
  input  logic          rw,
  input  logic [1:0]    size,
  input  logic          sign,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out,
  output logic          mfc,
  output logic          align_err
);

  localparam logic [3:0] LAST      = 4'(LATENCY - 1);
  localparam bit         ONE_CYCLE = (LATENCY == 1);

  logic [7:0] mem [DEPTH];

  state_t state, next;
  logic [3:0]    cnt;
  logic          rw_q, sign_q, err_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;

  logic          accept, illegal, commit;
  logic          a_rw, a_sign;
  logic [1:0]    a_size;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_data;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   rd_word, ld_data, st_word;
  logic [3:0]    st_be;

  assign accept  = (state == IDLE) && mov;
  assign illegal = req_illegal(size, addr[1:0]);

  // With LATENCY=1 the commit happens on the sample edge, so the live inputs
  // must feed the datapath before they reach the request registers.
  always_comb begin
    if (state == IDLE) begin
      a_rw   = rw;
      a_size = size;
      a_sign = sign;
      a_addr = addr;
      a_data = data_in;
    end else begin
      a_rw   = rw_q;
      a_size = size_q;
      a_sign = sign_q;
      a_addr = addr_q;
      a_data = data_q;
    end
  end

  assign commit = (accept && !illegal && ONE_CYCLE) ||
                  ((state == BUSY) && (cnt == LAST));

  assign idx0 = a_addr;
  assign idx1 = a_addr + AW'(1);
  assign idx2 = a_addr + AW'(2);
  assign idx3 = a_addr + AW'(3);
  assign rd_word = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};

  mem_lane_align u_align (
    .size    (a_size),
    .sign    (a_sign),
    .rd_word (rd_word),
    .wr_data (a_data),
    .ld_data (ld_data),
    .st_word (st_word),
    .st_be   (st_be)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (mov) next = (illegal || ONE_CYCLE) ? DONE : BUSY;
      BUSY: if (cnt == LAST) next = DONE;
      DONE: if (!mov) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    mfc       = (state == DONE);
    align_err = (state == DONE) && err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      rw_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      sign_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      data_out <= '0;
    end else begin
      if (accept) begin
        rw_q   <= rw;
        size_q <= size;
        sign_q <= sign;
        addr_q <= addr;
        data_q <= data_in;
        err_q  <= illegal;
      end
      if (accept && !illegal && !ONE_CYCLE)
        cnt <= 4'd1;
      else if (state == BUSY)
        cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
      if (commit && a_rw)
        data_out <= ld_data;
    end
  end

  // Contents survive reset; reset only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (commit && !a_rw && !reset) begin
      if (st_be[3]) mem[idx0] <= st_word[31:24];
      if (st_be[2]) mem[idx1] <= st_word[23:16];
      if (st_be[1]) mem[idx2] <= st_word[15:8];
      if (st_be[0]) mem[idx3] <= st_word[7:0];
    end
  end

endmodule
